// File: rtl/mem_copy_engine.sv
// Word-memory copy engine: streams reads from a source range and writes the
// returned words to a destination range, hiding the fixed memory read latency.
module mem_copy_engine #(
    parameter int READ_LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:1] i_src_addr,
    input  logic [15:1] i_dst_addr,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:1] o_mem_raddr,
    input  logic [15:0] i_mem_rdata,
    output logic        o_mem_wen,
    output logic [15:1] o_mem_waddr,
    output logic [15:0] o_mem_wdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:1]             r_raddr;
    logic [15:1]             r_dst;
    logic [15:0]             r_len;
    logic [15:0]             r_icnt;
    logic [15:0]             r_wcnt;
    logic [READ_LATENCY-1:0] r_vld;
    logic [READ_LATENCY:0]   w_vld_shift;

    logic w_accept;
    logic w_issue;
    logic w_last_issue;
    logic w_wen;
    logic w_last_write;

    assign w_accept     = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_issue      = (r_state == S_ISSUE);
    assign w_last_issue = w_issue && (r_icnt == (r_len - 16'd1));
    // The tail of the valid pipe marks the cycle a read's data is on i_mem_rdata.
    assign w_wen        = r_vld[READ_LATENCY-1];
    assign w_last_write = w_wen && (r_wcnt == (r_len - 16'd1));
    assign w_vld_shift  = {r_vld, w_issue};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next = (i_len == 16'd0) ? S_DONE : S_ISSUE;
                end else if (r_state == S_DONE) begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_last_issue) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_write) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_raddr <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_icnt  <= '0;
            r_wcnt  <= '0;
            r_vld   <= '0;
        end else begin
            r_vld <= w_vld_shift[READ_LATENCY-1:0];
            if (w_accept) begin
                r_raddr <= i_src_addr;
                r_dst   <= i_dst_addr;
                r_len   <= i_len;
                r_icnt  <= '0;
                r_wcnt  <= '0;
            end else begin
                // The read address holds on the final issue so it stays stable through DRAIN.
                if (w_issue && !w_last_issue) begin
                    r_raddr <= r_raddr + 15'd1;
                    r_icnt  <= r_icnt + 16'd1;
                end
                if (w_wen) begin
                    r_wcnt <= r_wcnt + 16'd1;
                end
            end
        end
    end

    assign o_busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign o_done      = (r_state == S_DONE);
    assign o_mem_raddr = r_raddr;
    assign o_mem_wen   = w_wen;
    assign o_mem_waddr = r_dst + r_wcnt[14:0];
    assign o_mem_wdata = i_mem_rdata;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural two-cycle word memory;
// inputs change and outputs are sampled on the falling clock edge.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [15:1] srcAddr;
    logic [15:1] dstAddr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [15:1] memRaddr;
    logic [15:0] memRdata;
    logic        memWen;
    logic [15:1] memWaddr;
    logic [15:0] memWdata;

    logic [15:0] mem [32768];
    logic [15:1] rdAddrQ;
    int          wenCount = 0;

    int nVectors     = 0;
    int nMiscompares = 0;

    mem_copy_engine #(.READ_LATENCY(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (start),
        .i_src_addr  (srcAddr),
        .i_dst_addr  (dstAddr),
        .i_len       (len),
        .o_busy      (busy),
        .o_done      (done),
        .o_mem_raddr (memRaddr),
        .i_mem_rdata (memRdata),
        .o_mem_wen   (memWen),
        .o_mem_waddr (memWaddr),
        .o_mem_wdata (memWdata)
    );

    always #5 clk = ~clk;

    // Registered address then registered data: two cycles of read latency.
    always @(posedge clk) begin
        rdAddrQ  <= memRaddr;
        memRdata <= mem[rdAddrQ];
        if (memWen) begin
            mem[memWaddr] = memWdata;
            wenCount <= wenCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        assert (observed === expected)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of c0.
    task automatic applyStimulus(input logic [15:1] src, input logic [15:1] dst, input logic [15:0] n);
        srcAddr = src;
        dstAddr = dst;
        len     = n;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, output int cycles);
        cycles = -1;
        for (int k = 1; k <= maxCycles; k++) begin
            @(negedge clk);
            if (done) begin
                cycles = k;
                break;
            end
        end
        if (cycles < 0) begin
            checkOutput("done timeout", 32'(cycles), 32'(maxCycles));
        end
    endtask

    initial begin
        int cycles;
        int snap;
        int badWords;
        logic [15:0] refData [300];

        for (int a = 0; a < 32768; a++) mem[a] = 16'h0000;
        for (int k = 0; k < 4; k++) mem[16 + k] = 16'hA001 + 16'(k);
        mem[15'h7ffe] = 16'd1;
        mem[15'h7fff] = 16'd2;
        mem[0]        = 16'd3;
        mem[1]        = 16'd4;
        for (int k = 0; k < 4; k++) mem[40 + k] = 16'hB001 + 16'(k);
        mem[60] = 16'hC0DE;
        mem[61] = 16'hC0DF;
        for (int k = 0; k < 8; k++) mem[200 + k] = 16'hD000 + 16'(k);
        for (int k = 0; k < 300; k++) begin
            refData[k]    = 16'h1234 + 16'(k * 7);
            mem[1000 + k] = refData[k];
        end

        rstN = 1'b0;
        start = 1'b0;
        srcAddr = '0;
        dstAddr = '0;
        len = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset wen", 32'(memWen), 32'd0);
        checkOutput("reset raddr", 32'(memRaddr), 32'd0);
        checkOutput("reset waddr", 32'(memWaddr), 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Basic 4-word copy, cycle by cycle from c0 to c7.
        $display("[TB] basic copy 16->32 len 4");
        applyStimulus(15'd16, 15'd32, 16'd4);
        for (int i = 0; i <= 6; i++) begin
            checkOutput($sformatf("basic raddr c%0d", i), 32'(memRaddr), 32'd16 + 32'((i < 3) ? i : 3));
            checkOutput($sformatf("basic wen c%0d", i), 32'(memWen), 32'((i >= 2) && (i <= 5)));
            checkOutput($sformatf("basic busy c%0d", i), 32'(busy), 32'(i <= 5));
            checkOutput($sformatf("basic done c%0d", i), 32'(done), 32'(i == 6));
            if ((i >= 2) && (i <= 5)) begin
                checkOutput($sformatf("basic waddr c%0d", i), 32'(memWaddr), 32'd32 + 32'(i - 2));
                checkOutput($sformatf("basic wdata c%0d", i), 32'(memWdata), 32'h0000A001 + 32'(i - 2));
            end
            @(negedge clk);
        end
        checkOutput("basic done c7", 32'(done), 32'd0);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("basic mem[%0d]", 32 + k), 32'(mem[32 + k]), 32'h0000A001 + 32'(k));

        // Zero-length request completes immediately with no memory traffic.
        $display("[TB] zero length");
        snap = wenCount;
        srcAddr = 15'd16;
        dstAddr = 15'd500;
        len = 16'd0;
        start = 1'b1;
        checkOutput("len0 busy at accept", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("len0 done c0", 32'(done), 32'd1);
        checkOutput("len0 busy c0", 32'(busy), 32'd0);
        checkOutput("len0 wen c0", 32'(memWen), 32'd0);
        @(negedge clk);
        checkOutput("len0 done c1", 32'(done), 32'd0);
        checkOutput("len0 busy c1", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("len0 no writes", 32'(wenCount - snap), 32'd0);

        // Source and destination both wrap at the top of the address space.
        $display("[TB] address wrap");
        applyStimulus(15'h7ffe, 15'h0100, 16'd4);
        checkOutput("wrap raddr c0", 32'(memRaddr), 32'h7ffe);
        @(negedge clk);
        checkOutput("wrap raddr c1", 32'(memRaddr), 32'h7fff);
        @(negedge clk);
        checkOutput("wrap raddr c2", 32'(memRaddr), 32'h0000);
        @(negedge clk);
        checkOutput("wrap raddr c3", 32'(memRaddr), 32'h0001);
        waitDone(10, cycles);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("wrap mem[%0h]", 16'h100 + k), 32'(mem[16'h100 + k]), 32'(k + 1));

        // Start during a copy is ignored; start in the DONE cycle chains a new copy.
        $display("[TB] start while busy, then back-to-back");
        snap = wenCount;
        applyStimulus(15'd40, 15'd48, 16'd4);
        @(negedge clk);
        srcAddr = 15'd60;
        dstAddr = 15'd64;
        len = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(10, cycles);
        checkOutput("ignore done cycle", 32'(cycles), 32'd4);
        checkOutput("ignore write count", 32'(wenCount - snap), 32'd4);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("ignore mem[%0d]", 48 + k), 32'(mem[48 + k]), 32'h0000B001 + 32'(k));
        checkOutput("ignore mem[64]", 32'(mem[64]), 32'd0);
        applyStimulus(15'd60, 15'd70, 16'd2);
        checkOutput("chain busy c0", 32'(busy), 32'd1);
        checkOutput("chain raddr c0", 32'(memRaddr), 32'd60);
        checkOutput("chain done c0", 32'(done), 32'd0);
        waitDone(10, cycles);
        checkOutput("chain done cycle", 32'(cycles), 32'd4);
        checkOutput("chain mem[70]", 32'(mem[70]), 32'h0000C0DE);
        checkOutput("chain mem[71]", 32'(mem[71]), 32'h0000C0DF);

        // Asynchronous reset in the middle of a copy abandons it.
        $display("[TB] reset mid-copy");
        @(negedge clk);
        applyStimulus(15'd200, 15'd300, 16'd8);
        @(negedge clk);
        @(negedge clk);
        snap = wenCount;
        rstN = 1'b0;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset wen", 32'(memWen), 32'd0);
        checkOutput("midreset raddr", 32'(memRaddr), 32'd0);
        checkOutput("midreset waddr", 32'(memWaddr), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("midreset no writes", 32'(wenCount - snap), 32'd0);
        checkOutput("midreset mem[300]", 32'(mem[300]), 32'd0);
        checkOutput("midreset idle busy", 32'(busy), 32'd0);
        applyStimulus(15'd200, 15'd400, 16'd8);
        waitDone(20, cycles);
        checkOutput("post-reset done cycle", 32'(cycles), 32'd10);
        for (int k = 0; k < 8; k++) checkOutput($sformatf("post-reset mem[%0d]", 400 + k), 32'(mem[400 + k]), 32'h0000D000 + 32'(k));

        // Long copy against the reference data table.
        $display("[TB] 300-word copy");
        @(negedge clk);
        snap = wenCount;
        applyStimulus(15'd1000, 15'd5000, 16'd300);
        waitDone(400, cycles);
        checkOutput("len300 done cycle", 32'(cycles), 32'd302);
        checkOutput("len300 write count", 32'(wenCount - snap), 32'd300);
        badWords = 0;
        for (int k = 0; k < 300; k++) if (mem[5000 + k] !== refData[k]) badWords++;
        checkOutput("len300 bad words", 32'(badWords), 32'd0);
        checkOutput("len300 mem[5300] untouched", 32'(mem[5300]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator/master for the single-read-port, single-write-port word memory.
- Copies `len` 16-bit words from word address `src_addr` to `dst_addr`.
- Issues one read per cycle, absorbs the memory's fixed 2-cycle read latency with a valid pipeline, and writes each returned word back through the memory's write port.
- Sits between a control source (CPU/testbench) and the memory, as the driver side of the memory's read-address/read-data/write interface.

Parameters:
- READ_LATENCY, 2, cycles from read address presented to data valid on `mem_rdata`; must match the memory (registered address plus registered data). Legal values 1..4.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only when the engine is not busy.
- src_addr  in  15 [15:1]  source word address.
- dst_addr  in  15 [15:1]  destination word address.
- len  in  16  word count, 0..65535.
- busy  out  1  high while a copy is in progress.
- done  out  1  one-cycle completion pulse.
- mem_raddr  out  15 [15:1]  read address to memory.
- mem_rdata  in  16  read data from memory, valid READ_LATENCY cycles after address.
- mem_wen  out  1  write enable to memory.
- mem_waddr  out  15 [15:1]  write address to memory.
- mem_wdata  out  16  write data to memory.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE.
  - `busy`=0, `done`=0, `mem_wen`=0, `mem_raddr`=0, `mem_waddr`=0.
  - Issue and write counters=0, valid pipeline cleared.
  - Takes effect immediately, including mid-copy. The partial copy is abandoned and no further writes occur.
- States:
  - IDLE, ISSUE, DRAIN, DONE.
  - `start` is accepted in IDLE or DONE. `start` in ISSUE or DRAIN is ignored.
  - `src_addr`, `dst_addr` and `len` are latched on acceptance and may change afterwards.
- Acceptance with `len`=0:
  - Next state is DONE; `done`=1 for one cycle.
  - No read is issued; `mem_wen` stays 0.
  - `busy` stays 0.
- Acceptance with `len`=N>0:
  - Let c0 be the first cycle after the accepting edge.
  - State ISSUE, `busy`=1.
  - In cycle c0+i (i=0..N-1), `mem_raddr` = `src_addr`+i. `mem_raddr` is registered.
  - After the read for i=N-1 is issued, next state is DRAIN. `mem_raddr` holds its last value.
- Valid pipeline:
  - A READ_LATENCY-deep shift register of valid bits, fed 1 on each issue cycle.
  - When the tail bit is 1 in cycle c0+i+READ_LATENCY:
    - `mem_wen`=1
    - `mem_waddr`=`dst_addr`+j, where j is the write counter
    - `mem_wdata`=`mem_rdata` (combinational pass-through)
    - j increments.
  - Writes occur in strict order, exactly one per returned word. `mem_wen` is 0 in every other cycle.
- Completion:
  - DRAIN moves to DONE after write j=N-1 (cycle c0+N+READ_LATENCY-1).
  - DONE lasts exactly one cycle (c0+N+READ_LATENCY) with `done`=1 and `busy`=0.
  - Then IDLE, unless `start` is accepted in that DONE cycle.
- Address arithmetic: modulo 2^15. Addresses wrap 0x7fff→0x0000 on both source and destination.
- Overlap:
  - Disjoint ranges, and `dst_addr` < `src_addr`, copy exactly.
  - `dst_addr` inside (`src_addr`, `src_addr`+N) gives an unspecified result and is not supported.
- Throughput: N words in N+READ_LATENCY+1 cycles from acceptance to `done`.

Test Plan:
- mem[16..19]=0xA001..0xA004, `start` with src=16, dst=32, len=4 → `mem_raddr` 16,17,18,19 in c0..c3; `mem_wen` high c2..c5 with waddr 32..35 and wdata A001..A004; `done` in c6; mem[32..35] match.
- len=0 → `done` pulse the cycle after acceptance, `busy` never 1, `mem_wen` never 1.
- src=0x7ffe, dst=0x0100, len=4 with mem[0x7ffe]=1, mem[0x7fff]=2, mem[0]=3, mem[1]=4 → reads 7ffe,7fff,0000,0001; mem[0x100..0x103]=1,2,3,4.
- `start` pulsed mid-copy with different src/dst → ignored; only the original 4 writes occur; then `start` asserted in the DONE cycle → new copy starts next cycle, no idle gap.
- `rst_n` low for 1 cycle at c2 of an 8-word copy → outputs 0 immediately, no writes after reset, state IDLE; a subsequent copy completes correctly.
- len=300 disjoint copy against a reference model → all 300 words correct, exactly 300 `mem_wen` cycles, `done` at c0+302.
